// File: rtl/max_scanner.sv
// Multi-cycle max finder: scans CH_N channels GRP_N per cycle, keeping a running best above a threshold.
// Optional early exit once the best reaches all-ones: define MAX_SCANNER_EARLY_EXIT_EN.
module max_scanner #(
  parameter int CH_N  = 32,
  parameter int VAL_W = 3,
  parameter int PLD_W = 5,
  parameter int GRP_N = 4,
  localparam int GRP_CNT = (CH_N + GRP_N - 1) / GRP_N,
  localparam int IDX_W   = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [VAL_W-1:0]       i_thr,
  input  logic [CH_N*VAL_W-1:0]  i_val,
  input  logic [CH_N*PLD_W-1:0]  i_pld,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic                   o_found,
  output logic [VAL_W-1:0]       o_val,
  output logic [PLD_W-1:0]       o_pld,
  output logic [IDX_W-1:0]       o_idx
);

  localparam int CNT_W = (GRP_CNT > 1) ? $clog2(GRP_CNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [VAL_W-1:0]   thr_q,   thr_d;
  logic               found_q, found_d;
  logic [VAL_W-1:0]   val_q,   val_d;
  logic [PLD_W-1:0]   pld_q,   pld_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;

  // Channels laid out as [group][slot]; slots past CH_N are padding and never eligible.
  logic [VAL_W-1:0]   slot_val [GRP_CNT][GRP_N];
  logic [PLD_W-1:0]   slot_pld [GRP_CNT][GRP_N];
  logic [IDX_W-1:0]   slot_idx [GRP_CNT][GRP_N];
  logic               slot_ok  [GRP_CNT][GRP_N];

  for (genvar g = 0; g < GRP_CNT; g++) begin : g_grp
    for (genvar j = 0; j < GRP_N; j++) begin : g_slot
      localparam int CH = g * GRP_N + j;
      if (CH < CH_N) begin : g_real
        assign slot_val[g][j] = i_val[CH*VAL_W +: VAL_W];
        assign slot_pld[g][j] = i_pld[CH*PLD_W +: PLD_W];
        assign slot_idx[g][j] = IDX_W'(CH);
        assign slot_ok[g][j]  = 1'b1;
      end else begin : g_pad
        assign slot_val[g][j] = '0;
        assign slot_pld[g][j] = '0;
        assign slot_idx[g][j] = '0;
        assign slot_ok[g][j]  = 1'b0;
      end
    end
  end

  logic               win_found;
  logic [VAL_W-1:0]   win_val;
  logic [PLD_W-1:0]   win_pld;
  logic [IDX_W-1:0]   win_idx;

  // Group reduction: strict '>' keeps the lowest slot on equal values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_val   = '0;
    win_pld   = '0;
    win_idx   = '0;
    for (int j = 0; j < GRP_N; j++) begin
      if (slot_ok[cnt_q][j] && (slot_val[cnt_q][j] > thr_q) &&
          (!win_found || (slot_val[cnt_q][j] > win_val))) begin
        win_found = 1'b1;
        win_val   = slot_val[cnt_q][j];
        win_pld   = slot_pld[cnt_q][j];
        win_idx   = slot_idx[cnt_q][j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    found_d = found_q;
    val_d   = val_q;
    pld_d   = pld_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          thr_d   = i_thr;
          found_d = 1'b0;
          val_d   = '0;
          pld_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Later groups only win on a strictly greater value, so cross-group ties keep the lower index.
        if (win_found && (!found_q || (win_val > val_q))) begin
          found_d = 1'b1;
          val_d   = win_val;
          pld_d   = win_pld;
          idx_d   = win_idx;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GRP_CNT - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
`ifdef MAX_SCANNER_EARLY_EXIT_EN
        if (found_d && (val_d == {VAL_W{1'b1}})) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      thr_q   <= '0;
      found_q <= 1'b0;
      val_q   <= '0;
      pld_q   <= '0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      found_q <= found_d;
      val_q   <= val_d;
      pld_q   <= pld_d;
      idx_q   <= idx_d;
    end
  end

  assign o_busy  = (state_q != ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_found = found_q;
  assign o_val   = val_q;
  assign o_pld   = pld_q;
  assign o_idx   = idx_q;

endmodule

// File: doc/max_scanner.md
Name: max_scanner

Overview:
- Sequential, multi-cycle successor to the combinational max finder, for large channel counts (e.g. PLIC sources).
- Scans CH_N channels GRP_N per cycle, reducing each group with a combinational max and keeping a running best.
- Reports the maximum eligible value, its payload and its channel index.
- Eligible means value > threshold. Ties go to the lowest channel index.
- Start/done handshake; trades latency for area.

Parameters:
- CH_N, 32: number of channels (>=1).
- VAL_W, 3: value width.
- PLD_W, 5: payload width.
- GRP_N, 4: channels compared per scan cycle (1..CH_N).
- Derived (localparam): GRP_CNT = ceil(CH_N/GRP_N); IDX_W = max(1, clog2(CH_N)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  scan request; accepted only when o_busy=0.
- i_thr  in  VAL_W  threshold; latched on accept.
- i_val  in  CH_N*VAL_W  packed per-channel values; must be held stable while o_busy=1.
- i_pld  in  CH_N*PLD_W  packed per-channel payloads; must be held stable while o_busy=1.
- o_busy  out  1  high in SCAN and DONE.
- o_valid  out  1  one-cycle pulse: result is valid.
- o_found  out  1  at least one eligible channel.
- o_val  out  VAL_W  best value (0 if none found).
- o_pld  out  PLD_W  payload of best channel (0 if none found).
- o_idx  out  IDX_W  index of best channel (0 if none found).

Behaviour:
- Reset: state=IDLE, group counter=0, latched thr=0. All outputs 0: o_busy, o_valid, o_found, o_val, o_pld, o_idx.
- Reset mid-scan aborts immediately; no o_valid is produced.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE, i_start=1:
  - latch i_thr; clear running best (found=0, val=0, pld=0, idx=0); counter=0; go to SCAN.
- SCAN, each cycle, group g = counter covers channels g*GRP_N .. g*GRP_N+GRP_N-1:
  - Channels >= CH_N (last partial group) are padding and never eligible.
  - Group winner = first channel with maximal value among eligible channels (val > thr, unsigned).
  - Running best is replaced only if found=0 or winner value is strictly greater. This keeps the lowest index on ties across groups.
  - Counter increments. After group GRP_CNT-1, go to DONE.
- DONE, exactly one cycle:
  - o_valid=1; go to IDLE.
- Result registers:
  - o_found/o_val/o_pld/o_idx update during SCAN.
  - They hold the final result from DONE until the next accepted start, which clears them.
- Latency: accept at edge T0; SCAN occupies cycles 1..GRP_CNT; o_valid high in cycle GRP_CNT+1. Next accept is possible at the edge ending that cycle.
- i_start while o_busy=1 is ignored (not queued).
- thr = all-ones means nothing is eligible: o_found=0, o_val=o_pld=o_idx=0.
- thr = 0 means a value of 0 is never eligible.
- GRP_N >= CH_N: single SCAN cycle; o_valid in cycle 2.

Optional Feature:
- Macro: MAX_SCANNER_EARLY_EXIT_EN.
- When defined:
  - If the running best, after a SCAN update, equals all-ones (2^VAL_W-1), go straight to DONE. Remaining groups are skipped; no later channel can exceed the best, and ties keep the earlier index.
  - Latency becomes variable, between 2 and GRP_CNT+1 cycles.
- When undefined: always scan all GRP_CNT groups; fixed latency GRP_CNT+1.
- Result values are identical in both builds.

Test Plan (CH_N=8, VAL_W=3, PLD_W=4, GRP_N=3 unless noted):
- Reset/idle:
  - Stimulus: assert rst mid-scan, release, no start.
  - Required: all outputs 0; no o_valid.
- Basic:
  - Stimulus: thr=0; vals {1,2,5,3,0,4,2,1}; pld[i]=i+8.
  - Required: o_valid in cycle 4; found=1, val=5, pld=10, idx=2; o_busy high cycles 1-4.
- Tie across groups:
  - Stimulus: vals {0,6,0,0,6,0,6,0}, thr=2.
  - Required: idx=1, val=6. Also vals {0,0,0,4,4,0,0,0} gives idx=3.
- Threshold / none eligible:
  - Stimulus: vals all 3, thr=3.
  - Required: found=0, val=pld=idx=0. With thr=2: idx=0, val=3.
- Padding and start while busy:
  - Stimulus: vals {0,0,0,0,0,0,1,7}, thr=0.
  - Required: idx=7, val=7 (last partial group).
  - Stimulus: i_start pulsed at cycle 2.
  - Required: ignored; a single o_valid.
- Early exit (macro defined):
  - Stimulus: vals {7,0,0,0,0,0,0,7}.
  - Required: o_valid in cycle 2, idx=0. Same result, o_valid in cycle 4, with the macro undefined.
